pc_gen: RTL and testbench

- Parametrised program-counter and fetch-address generator for the 5-stage core; successor to the single-register PC.
- Adds prioritised trap and branch redirects, a fetch valid/ready handshake, and a pending-redirect buffer so a redirect raised during a stall is never lost.
- Sits at the head of IF and drives the instruction-memory address and the PC+INC value used by the writeback mux.

---
 rtl/pc_gen.sv | 214 +++++++++++++++++++++
 tb/tb_pc_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter and fetch-address generator at the head of IF.
// Provides prioritised trap/branch redirects, a fetch valid/ready handshake,
// and a one-entry pending-redirect buffer so that a redirect raised while
// the pipeline is stalled is applied once the PC is allowed to advance.
//
// Optional feature macro: PC_MISALIGN_CHK_EN
//   When defined, redirect targets have bits [1:0] cleared before they are
//   used, and o-misaligned pulses for one cycle after such a target lands
//   on pc_out. When undefined, targets are used verbatim and misaligned is 0.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int              INC          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            fetch_ready,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            redirect_pending,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend_mis;
  logic            r_mis;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            w_pend_mis_nxt;
  logic            w_mis_nxt;

  logic            w_adv;
  logic            w_req;
  logic [XLEN-1:0] w_req_pc;
  logic [XLEN-1:0] w_req_tgt;
  logic            w_req_mis;
  logic [XLEN-1:0] w_pc_plus;

  // The PC may only move once out of BOOT and when both the hazard unit and
  // the instruction memory agree.
  assign w_adv     = pc_write & fetch_ready & (r_state != ST_BOOT);
  assign w_req     = trap_valid | redirect_valid;
  // Trap outranks a branch/jump redirect raised in the same cycle.
  assign w_req_pc  = trap_valid ? trap_pc : redirect_pc;
  assign w_pc_plus = r_pc + XLEN'(INC);

`ifdef PC_MISALIGN_CHK_EN
  assign w_req_tgt = {w_req_pc[XLEN-1:2], 2'b00};
  assign w_req_mis = |w_req_pc[1:0];
`else
  assign w_req_tgt = w_req_pc;
  assign w_req_mis = 1'b0;
`endif

  // State register: BOOT on reset, otherwise follow the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a stalled redirect parks the FSM in PEND until the PC
  // can advance; BOOT always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: begin
        if (w_req) begin
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_adv) begin
          w_state_nxt = ST_RUN;
        end else if (w_req) begin
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PEND: begin
        if (w_adv) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_PEND;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Output decode: fetch only in RUN so the wrong path is never presented
  // while a redirect is waiting in the buffer.
  always_comb begin
    fetch_valid      = 1'b0;
    redirect_pending = 1'b0;
    case (r_state)
      ST_RUN: begin
        fetch_valid      = 1'b1;
        redirect_pending = 1'b0;
      end
      ST_PEND: begin
        fetch_valid      = 1'b0;
        redirect_pending = 1'b1;
      end
      default: begin
        fetch_valid      = 1'b0;
        redirect_pending = 1'b0;
      end
    endcase
  end

  // Datapath next values: select the new PC and maintain the pending buffer.
  // Priority is trap, redirect, buffered target, then sequential PC.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_pend_mis_nxt = r_pend_mis;
    w_mis_nxt      = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (w_req) begin
          w_pend_pc_nxt  = w_req_tgt;
          w_pend_mis_nxt = w_req_mis;
        end else begin
          w_pend_pc_nxt  = r_pend_pc;
          w_pend_mis_nxt = r_pend_mis;
        end
      end
      ST_RUN: begin
        if (w_adv) begin
          if (w_req) begin
            w_pc_nxt  = w_req_tgt;
            w_mis_nxt = w_req_mis;
          end else begin
            w_pc_nxt  = w_pc_plus;
          end
        end else if (w_req) begin
          w_pend_pc_nxt  = w_req_tgt;
          w_pend_mis_nxt = w_req_mis;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_PEND: begin
        if (w_adv) begin
          if (w_req) begin
            w_pc_nxt  = w_req_tgt;
            w_mis_nxt = w_req_mis;
          end else begin
            w_pc_nxt  = r_pend_pc;
            w_mis_nxt = r_pend_mis;
          end
          w_pend_pc_nxt  = '0;
          w_pend_mis_nxt = 1'b0;
        end else if (w_req) begin
          w_pend_pc_nxt  = w_req_tgt;
          w_pend_mis_nxt = w_req_mis;
        end else begin
          w_pend_pc_nxt  = r_pend_pc;
          w_pend_mis_nxt = r_pend_mis;
        end
      end
      default: begin
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = '0;
        w_pend_mis_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers: PC, pending target and the one-cycle misaligned pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_pend_pc  <= '0;
      r_pend_mis <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_pend_mis <= w_pend_mis_nxt;
      r_mis      <= w_mis_nxt;
    end
  end

  assign pc_out      = r_pc;
  assign pc_plus_inc = w_pc_plus;
  assign misaligned  = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen (default parameters).
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        fetch_ready;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        redirect_pending;
  logic        misaligned;

  int n_checks;
  int n_fail;

  pc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_write         (pc_write),
    .fetch_ready      (fetch_ready),
    .trap_valid       (trap_valid),
    .trap_pc          (trap_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_valid      (fetch_valid),
    .pc_out           (pc_out),
    .pc_plus_inc      (pc_plus_inc),
    .redirect_pending (redirect_pending),
    .misaligned       (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        fr;
    logic        tv;
    logic [31:0] tpc;
    logic        rv;
    logic [31:0] rpc;
    logic        efv;
    logic [31:0] epc;
    logic        epend;
    logic        emis;
  } vec_t;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [31:0] MIS_PC   = 32'h8000_0100;
  localparam logic        MIS_FLAG = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h8000_0102;
  localparam logic        MIS_FLAG = 1'b0;
`endif

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic pw, input logic fr,
                              input logic tv, input logic [31:0] tpc,
                              input logic rv, input logic [31:0] rpc,
                              input logic efv, input logic [31:0] epc,
                              input logic epend, input logic emis);
    vec_t v;
    v.pw = pw; v.fr = fr; v.tv = tv; v.tpc = tpc; v.rv = rv; v.rpc = rpc;
    v.efv = efv; v.epc = epc; v.epend = epend; v.emis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Compare every output against an expected snapshot.
  task automatic check_all(input string tag, input logic efv, input logic [31:0] epc,
                           input logic epend, input logic emis);
    logic [31:0] epi;
    epi = epc + 32'd4;
    check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
    check({tag, ".pc_out"}, pc_out, epc);
    check({tag, ".pc_plus_inc"}, pc_plus_inc, epi);
    check({tag, ".redirect_pending"}, {31'd0, redirect_pending}, {31'd0, epend});
    check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, emis});
  endtask

  task automatic drive(input logic pw, input logic fr, input logic tv,
                       input logic [31:0] tpc, input logic rv, input logic [31:0] rpc);
    pc_write       = pw;
    fetch_ready    = fr;
    trap_valid     = tv;
    trap_pc        = tpc;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

    //                pw    fr    tv    tpc            rv    rpc            fv    pc             pend  mis
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0004, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0008, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_000C, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0010, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0104, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0200, 1'b0, 32'h8000_0104, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h8000_0104, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h8000_0104, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h8000_0104, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0200, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0300, 1'b0, 32'h8000_0040, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 32'h8000_0080, 1'b0, 32'h0,         1'b0, 32'h8000_0040, 1'b1, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0080, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0500, 1'b0, 32'h8000_0080, 1'b1, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0600, 1'b1, 32'h8000_0600, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8000_0600, 1'b0, 1'b0);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    vecs[20] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0102, 1'b1, MIS_PC,        1'b0, MIS_FLAG);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, MIS_PC + 32'd4, 1'b0, 1'b0);
    vecs[23] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0700, 1'b0, MIS_PC + 32'd4, 1'b1, 1'b0);

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

    // Release reset between edges; first cycle is BOOT.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("boot", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pw, vecs[i].fr, vecs[i].tv, vecs[i].tpc, vecs[i].rv, vecs[i].rpc);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].efv, vecs[i].epc, vecs[i].epend, vecs[i].emis);
      @(negedge clk);
    end

    // Now in PEND mid-stall: reset must act immediately, without a clock edge.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

    // Redirect raised in BOOT is buffered and applied once the PC may advance.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h8000_0800);
    @(posedge clk);
    #1;
    check_all("boot_redir", 1'b0, 32'h8000_0000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check_all("boot_apply", 1'b1, 32'h8000_0800, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_all("boot_step", 1'b1, 32'h8000_0804, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
